// File: rtl/pool_channel_sched.sv
// Per-channel max-pooling scheduler: kicks an address generator, reads the feature buffer, writes window maxima.
// Optional build macro POOL_SCHED_RELU_EN clamps negative pooled results to zero before writing.
module pool_channel_sched #(
  parameter int unsigned ADDR_WIDTH    = 12,
  parameter int unsigned HEIGHT_WIDTH  = 7,
  parameter int unsigned KERSIZE_WIDTH = 5,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned CH_WIDTH      = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en,
  input  logic                           start,
  input  logic [HEIGHT_WIDTH-1:0]        h,
  input  logic [HEIGHT_WIDTH-1:0]        w,
  input  logic [KERSIZE_WIDTH-1:0]       k,
  input  logic [KERSIZE_WIDTH-1:0]       l,
  input  logic [CH_WIDTH-1:0]            c,
  input  logic [ADDR_WIDTH-1:0]          base_in,
  input  logic [ADDR_WIDTH-1:0]          base_out,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  output logic                           ag_start,
  output logic [HEIGHT_WIDTH-1:0]        ag_h,
  output logic [HEIGHT_WIDTH-1:0]        ag_w,
  output logic [KERSIZE_WIDTH-1:0]       ag_k,
  output logic [KERSIZE_WIDTH-1:0]       ag_l,
  input  logic                           ag_valid,
  input  logic                           ag_pack,
  input  logic                           ag_last,
  input  logic [ADDR_WIDTH-1:0]          ag_bias,
  output logic                           rd_en,
  output logic [ADDR_WIDTH-1:0]          rd_addr,
  input  logic signed [DATA_WIDTH-1:0]   rd_data,
  output logic                           wr_en,
  output logic [ADDR_WIDTH-1:0]          wr_addr,
  output logic signed [DATA_WIDTH-1:0]   wr_data
);

  localparam int unsigned PROD_W = 2 * HEIGHT_WIDTH;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_KICK  = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_NEXT  = 3'd5;

  logic [2:0]                    state;
  logic [2:0]                    state_next;
  logic [CH_WIDTH-1:0]           c_q;
  logic [ADDR_WIDTH-1:0]         base_in_q;
  logic [ADDR_WIDTH-1:0]         base_out_q;
  logic [ADDR_WIDTH-1:0]         in_base;
  logic [ADDR_WIDTH-1:0]         out_addr;
  logic [ADDR_WIDTH-1:0]         stride;
  logic [CH_WIDTH-1:0]           ch;
  logic                          first;
  logic signed [DATA_WIDTH-1:0]  acc;
  logic                          pack1;
  logic                          last1;
  logic                          d_valid;
  logic                          d_pack;
  logic                          d_last;

  logic                          cfg_bad_c;
  logic                          last_ch_c;
  logic                          accept_c;
  logic [PROD_W-1:0]             area_c;
  logic signed [DATA_WIDTH-1:0]  max_c;
  logic signed [DATA_WIDTH-1:0]  out_c;

  assign cfg_bad_c = (ag_h == '0) || (ag_w == '0) || (ag_k == '0) || (ag_l == '0) ||
                     (c_q == '0) || (32'(ag_k) > 32'(ag_h)) || (32'(ag_l) > 32'(ag_w));
  assign last_ch_c = (ch + CH_WIDTH'(1)) == c_q;
  assign accept_c  = ag_valid && ((state == S_RUN) || (state == S_DRAIN));
  assign area_c    = PROD_W'(ag_h) * PROD_W'(ag_w);
  assign max_c     = (first || (rd_data > acc)) ? rd_data : acc;

`ifdef POOL_SCHED_RELU_EN
  assign out_c = max_c[DATA_WIDTH-1] ? '0 : max_c;
`else
  assign out_c = max_c;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else if (en) state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_CHECK;
      S_CHECK: state_next = cfg_bad_c ? S_IDLE : S_KICK;
      S_KICK:  state_next = S_RUN;
      S_RUN:   if (ag_valid && ag_last) state_next = S_DRAIN;
      S_DRAIN: if (d_valid && d_last) state_next = S_NEXT;
      S_NEXT:  state_next = last_ch_c ? S_IDLE : S_KICK;
      default: state_next = S_IDLE;
    endcase
  end

  // Registered outputs, job context and read/accumulate/write pipeline
  always_ff @(posedge clk) begin
    if (reset) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      ag_start   <= 1'b0;
      ag_h       <= '0;
      ag_w       <= '0;
      ag_k       <= '0;
      ag_l       <= '0;
      c_q        <= '0;
      base_in_q  <= '0;
      base_out_q <= '0;
      in_base    <= '0;
      out_addr   <= '0;
      stride     <= '0;
      ch         <= '0;
      first      <= 1'b0;
      acc        <= '0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      pack1      <= 1'b0;
      last1      <= 1'b0;
      d_valid    <= 1'b0;
      d_pack     <= 1'b0;
      d_last     <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else if (en) begin
      busy     <= state_next != S_IDLE;
      done     <= ((state == S_CHECK) && cfg_bad_c) || ((state == S_NEXT) && last_ch_c);
      err      <= (state == S_CHECK) && cfg_bad_c;
      ag_start <= state_next == S_KICK;

      if ((state == S_IDLE) && start) begin
        ag_h       <= h;
        ag_w       <= w;
        ag_k       <= k;
        ag_l       <= l;
        c_q        <= c;
        base_in_q  <= base_in;
        base_out_q <= base_out;
      end

      if ((state == S_CHECK) && !cfg_bad_c) begin
        in_base  <= base_in_q;
        out_addr <= base_out_q;
        ch       <= '0;
        stride   <= ADDR_WIDTH'(area_c);
      end

      if (state == S_NEXT) begin
        ch <= ch + CH_WIDTH'(1);
        if (!last_ch_c) in_base <= in_base + stride;
      end

      if (state == S_KICK) first <= 1'b1;

      rd_en <= accept_c;
      pack1 <= accept_c && ag_pack;
      last1 <= accept_c && ag_last;
      if (accept_c) rd_addr <= in_base + ag_bias;

      d_valid <= rd_en;
      d_pack  <= pack1;
      d_last  <= last1;

      // A packed read closes the window: emit it and restart the max on the next read
      wr_en <= d_valid && d_pack;
      if (d_valid) begin
        acc   <= max_c;
        first <= d_pack;
        if (d_pack) begin
          wr_data  <= out_c;
          wr_addr  <= out_addr;
          out_addr <= out_addr + ADDR_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pool_channel_sched.sv
// Directed bench for pool_channel_sched: bench-side address generator and feature buffer, hand-computed results.
module tb_pool_channel_sched;

  logic               clk = 1'b0;
  logic               reset, en, start;
  logic [6:0]         h, w;
  logic [4:0]         k, l;
  logic [7:0]         c;
  logic [11:0]        base_in, base_out;
  logic               busy, done, err, ag_start;
  logic [6:0]         ag_h, ag_w;
  logic [4:0]         ag_k, ag_l;
  logic               ag_valid, ag_pack, ag_last;
  logic [11:0]        ag_bias;
  logic               rd_en;
  logic [11:0]        rd_addr;
  logic signed [15:0] rd_data;
  logic               wr_en;
  logic [11:0]        wr_addr;
  logic signed [15:0] wr_data;

  logic signed [15:0] mem [0:4095];
  logic [11:0]        wa_q[$];
  logic [15:0]        wd_q[$];
  logic [11:0]        ra_q[$];
  int n_kick = 0, n_done = 0, n_err = 0, n_both = 0;
  int checks = 0, failures = 0;
  int e4[4]   = '{5, 7, 13, 15};
  int ord[16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};

  pool_channel_sched dut (
    .clk(clk), .reset(reset), .en(en), .start(start),
    .h(h), .w(w), .k(k), .l(l), .c(c), .base_in(base_in), .base_out(base_out),
    .busy(busy), .done(done), .err(err), .ag_start(ag_start),
    .ag_h(ag_h), .ag_w(ag_w), .ag_k(ag_k), .ag_l(ag_l),
    .ag_valid(ag_valid), .ag_pack(ag_pack), .ag_last(ag_last), .ag_bias(ag_bias),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  // Feature buffer: one enabled cycle of read latency
  always @(posedge clk) begin
    if (reset) rd_data <= '0;
    else if (en && rd_en) rd_data <= mem[rd_addr];
  end

  // Event monitor, counting only enabled cycles
  always @(negedge clk) begin
    if (en && !reset) begin
      if (wr_en) begin
        wa_q.push_back(wr_addr);
        wd_q.push_back(wr_data);
      end
      if (rd_en) ra_q.push_back(rd_addr);
      if (ag_start) n_kick++;
      if (done) n_done++;
      if (err) n_err++;
      if (done && err) n_both++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input int hh, input int ww, input int kk, input int ll, input int cc,
                         input int bin, input int bout, input int freeze_at);
    logic       seen;
    logic [63:0] snap_a, snap_b;
    int         idx;
    wa_q.delete(); wd_q.delete(); ra_q.delete();
    h = 7'(hh); w = 7'(ww); k = 5'(kk); l = 5'(ll); c = 8'(cc);
    base_in = 12'(bin); base_out = 12'(bout);
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int ch = 0; ch < cc; ch++) begin
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin
        @(negedge clk);
        seen = ag_start;
      end
      chk("kick_seen", 64'(seen), 64'(1));
      if (!seen) return;
      chk("busy_kick", 64'(busy), 64'(1));
      cycle();
      idx = 0;
      for (int wr = 0; wr < hh / kk; wr++)
        for (int wc = 0; wc < ww / ll; wc++)
          for (int dr = 0; dr < kk; dr++)
            for (int dc = 0; dc < ll; dc++) begin
              ag_valid = 1'b1;
              ag_bias  = 12'((wr * kk + dr) * ww + wc * ll + dc);
              ag_pack  = (dr == kk - 1) && (dc == ll - 1);
              ag_last  = ag_pack && (wr == hh / kk - 1) && (wc == ww / ll - 1);
              if (ch == 0 && idx == freeze_at) begin
                en = 1'b0;
                @(negedge clk);
                snap_a = {22'd0, rd_en, rd_addr, wr_en, wr_addr, wr_data};
                repeat (4) @(negedge clk);
                snap_b = {22'd0, rd_en, rd_addr, wr_en, wr_addr, wr_data};
                chk("freeze_hold", snap_b, snap_a);
                chk("freeze_busy", 64'(busy), 64'(1));
                cycle();
                en = 1'b1;
              end
              idx++;
              cycle();
            end
      ag_valid = 1'b0; ag_pack = 1'b0; ag_last = 1'b0;
    end
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      seen = done;
    end
    chk("done_seen", 64'(seen), 64'(1));
    cycle();
  endtask

  task automatic err_job(input int kk, input int ll);
    int kick0, rd0, wr0;
    kick0 = n_kick; rd0 = ra_q.size(); wr0 = wa_q.size();
    h = 7'd4; w = 7'd4; k = 5'(kk); l = 5'(ll); c = 8'd1;
    start = 1'b1;
    cycle();
    start = 1'b0;
    @(negedge clk);
    chk("err_early", 64'({done, err}), 64'(0));
    @(negedge clk);
    chk("err_pulse", 64'({done, err}), 64'(3));
    chk("err_busy", 64'(busy), 64'(0));
    @(negedge clk);
    chk("err_one_cycle", 64'({done, err}), 64'(0));
    chk("err_no_activity", 64'({n_kick - kick0, ra_q.size() - rd0, wa_q.size() - wr0}), 64'(0));
    cycle();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, got no summary expected finish");
    $fatal(1);
  end

  initial begin
    int d0, k0, e0, rd0, wr0;
    logic seen;
    for (int i = 0; i < 4096; i++) mem[i] = 16'(i);
    reset = 1'b1; en = 1'b1; start = 1'b0;
    h = '0; w = '0; k = '0; l = '0; c = '0; base_in = '0; base_out = '0;
    ag_valid = 1'b0; ag_pack = 1'b0; ag_last = 1'b0; ag_bias = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_flags", 64'({busy, done, err, ag_start, rd_en, wr_en}), 64'(0));
    chk("rst_addr", 64'({rd_addr, wr_addr, wr_data}), 64'(0));
    chk("rst_cfg", 64'({ag_h, ag_w, ag_k, ag_l}), 64'(0));
    cycle();
    reset = 1'b0;
    cycle();

    // Single channel 4x4, 2x2 windows
    d0 = n_done; k0 = n_kick; e0 = n_err;
    run_job(4, 4, 2, 2, 1, 0, 100, -1);
    chk("c1_cfg", 64'({ag_h, ag_w, ag_k, ag_l}), 64'({7'd4, 7'd4, 5'd2, 5'd2}));
    chk("c1_nwr", 64'(wa_q.size()), 64'(4));
    chk("c1_nrd", 64'(ra_q.size()), 64'(16));
    for (int j = 0; j < 4 && j < wa_q.size(); j++) begin
      chk("c1_wr_addr", 64'(wa_q[j]), 64'(100 + j));
      chk("c1_wr_data", 64'(wd_q[j]), 64'(e4[j]));
    end
    chk("c1_counts", 64'({8'(n_done - d0), 8'(n_kick - k0), 8'(n_err - e0)}), 64'({8'd1, 8'd1, 8'd0}));
    chk("c1_idle", 64'(busy), 64'(0));

    // Three channels from base 16, output addresses continuous
    d0 = n_done; k0 = n_kick;
    run_job(4, 4, 2, 2, 3, 16, 100, -1);
    chk("c3_nwr", 64'(wa_q.size()), 64'(12));
    chk("c3_nrd", 64'(ra_q.size()), 64'(48));
    chk("c3_kicks", 64'(n_kick - k0), 64'(3));
    chk("c3_done", 64'(n_done - d0), 64'(1));
    for (int j = 0; j < 48 && j < ra_q.size(); j++)
      chk("c3_rd_addr", 64'(ra_q[j]), 64'(16 * (j / 16 + 1) + ord[j % 16]));
    for (int j = 0; j < 12 && j < wa_q.size(); j++) begin
      chk("c3_wr_addr", 64'(wa_q[j]), 64'(100 + j));
      chk("c3_wr_data", 64'(wd_q[j]), 64'(16 * (j / 4 + 1) + e4[j % 4]));
    end

    // Rejected configurations
    err_job(0, 2);
    err_job(2, 5);
    chk("err_only_with_done", 64'(n_both), 64'(n_err));

    // Negative window data
    mem[200] = -16'sd5; mem[201] = -16'sd3; mem[202] = -16'sd9; mem[203] = -16'sd7;
    run_job(2, 2, 2, 2, 1, 200, 300, -1);
    chk("neg_nwr", 64'(wa_q.size()), 64'(1));
    if (wa_q.size() > 0) begin
      chk("neg_wr_addr", 64'(wa_q[0]), 64'(300));
`ifdef POOL_SCHED_RELU_EN
      chk("neg_wr_data", 64'(wd_q[0]), 64'(16'h0000));
`else
      chk("neg_wr_data", 64'(wd_q[0]), 64'(16'hFFFD));
`endif
    end

    // Enable dropped for five cycles mid-stream
    run_job(4, 4, 2, 2, 1, 0, 100, 6);
    chk("frz_nwr", 64'(wa_q.size()), 64'(4));
    for (int j = 0; j < 4 && j < wa_q.size(); j++) begin
      chk("frz_wr_addr", 64'(wa_q[j]), 64'(100 + j));
      chk("frz_wr_data", 64'(wd_q[j]), 64'(e4[j]));
    end

    // Reset mid-run aborts the job
    h = 7'd4; w = 7'd4; k = 5'd2; l = 5'd2; c = 8'd1; base_in = '0; base_out = 12'd100;
    start = 1'b1;
    cycle();
    start = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      seen = ag_start;
    end
    chk("rr_kick_seen", 64'(seen), 64'(1));
    cycle();
    for (int i = 0; i < 5; i++) begin
      ag_valid = 1'b1; ag_bias = 12'(ord[i]); ag_pack = (i == 3); ag_last = 1'b0;
      cycle();
    end
    reset = 1'b1;
    d0 = n_done;
    cycle();
    reset = 1'b0; ag_valid = 1'b0; ag_pack = 1'b0;
    @(negedge clk);
    chk("rr_after", 64'({busy, done, err, rd_en, wr_en}), 64'(0));
    rd0 = ra_q.size(); wr0 = wa_q.size();
    repeat (10) @(negedge clk);
    chk("rr_quiet", 64'({8'(ra_q.size() - rd0), 8'(wa_q.size() - wr0), 8'(n_done - d0)}), 64'(0));
    chk("rr_idle", 64'(busy), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pool_channel_sched.md
POOL_CHANNEL_SCHED -- requirements
Module: pool_channel_sched

Interface
REQ-001 Parameters: ADDR_WIDTH=12, address width; HEIGHT_WIDTH=7, H/W width; KERSIZE_WIDTH=5, K/L width; DATA_WIDTH=16, signed pixel width; CH_WIDTH=8, channel-count width.
REQ-002 CLK  in  1  single clock; all state on rising edge.
REQ-003 RESET  in  1  synchronous, active-high reset.
REQ-004 EN  in  1  global enable; when 0, all registers hold.
REQ-005 START  in  1  begin job, sampled only in IDLE; H/W/K/L/C/BASE_IN/BASE_OUT in  HEIGHT_WIDTH/HEIGHT_WIDTH/KERSIZE_WIDTH/KERSIZE_WIDTH/CH_WIDTH/ADDR_WIDTH/ADDR_WIDTH  job config, captured on accepted START.
REQ-006 BUSY  out  1  job in progress; DONE  out  1  one-cycle completion pulse; ERR  out  1  one-cycle reject pulse.
REQ-007 AG_START  out  1  start pulse to pooling address generator; AG_H/AG_W/AG_K/AG_L  out  generator config, driven from captured registers.
REQ-008 AG_VALID/AG_PACK/AG_LAST  in  1  generator address valid, window-last, stream-last flags; AG_BIAS  in  ADDR_WIDTH  generator offset.
REQ-009 RD_EN  out  1, RD_ADDR  out  ADDR_WIDTH  feature-buffer read; RD_DATA  in  DATA_WIDTH  valid exactly one enabled cycle after RD_EN.
REQ-010 WR_EN  out  1, WR_ADDR  out  ADDR_WIDTH, WR_DATA  out  DATA_WIDTH  pooled-result write.

Function
REQ-011 States IDLE, CHECK, KICK, RUN, DRAIN, NEXT; all transitions and outputs advance only when EN=1.
REQ-012 IDLE->CHECK on START; config captured same cycle; START while not IDLE ignored.
REQ-013 CHECK: any of H,W,K,L,C zero, or K>H, or L>W -> ERR pulse, DONE pulse, IDLE; else in_base=BASE_IN, out_addr=BASE_OUT, ch=0, stride=H*W (ADDR_WIDTH, truncated), ->KICK.
REQ-014 KICK: AG_START=1 exactly one cycle, ->RUN.
REQ-015 RUN: per cycle with AG_VALID=1, next cycle RD_EN=1, RD_ADDR=(in_base+AG_BIAS) mod 2^ADDR_WIDTH; PACK/LAST pipelined alongside.
REQ-016 Max accumulation: RD_DATA arriving with first-of-window flag loads acc; otherwise acc=signed max(acc,RD_DATA); first-of-window = first read of channel or read after a PACK read.
REQ-017 Read with PACK flag: following cycle WR_EN=1, WR_DATA=max(acc,RD_DATA), WR_ADDR=out_addr; out_addr increments by 1 (wraps mod 2^ADDR_WIDTH), continuous across channels.
REQ-018 AG_LAST sampled in RUN -> DRAIN; DRAIN waits until final write issued (3 cycles after last AG_VALID), ->NEXT.
REQ-019 NEXT: ch+1; if ch+1==C -> DONE pulse, IDLE; else in_base+=stride, ->KICK.
REQ-020 Total latency: AG_VALID at cycle t -> RD_EN t+1 -> RD_DATA t+2 -> WR_EN t+3.
REQ-021 BUSY=1 in every state except IDLE; DONE and ERR never both set except CHECK reject.
REQ-022 AG_VALID outside RUN/DRAIN ignored; no RD_EN issued.

Reset
REQ-023 RESET (sync, priority over EN) -> IDLE; BUSY, DONE, ERR, AG_START, RD_EN, WR_EN=0; RD_ADDR, WR_ADDR, WR_DATA, acc, ch, in_base, out_addr, captured config=0.
REQ-024 RESET mid-job aborts immediately; no further RD_EN/WR_EN; no DONE pulse.

Configuration
REQ-025 Macro POOL_SCHED_RELU_EN: defined -> WR_DATA = max(result,0) (negative results written as 0); undefined -> signed max written unmodified; timing identical either way.

Verification
REQ-026 H=4,W=4,K=2,L=2,C=1,BASE_IN=0,BASE_OUT=100, buffer[i]=i -> writes 100:5,101:7,102:13,103:15, then DONE.
REQ-027 Same with C=3, BASE_IN=16 -> RD_ADDR ranges 16..31,32..47,48..63; 12 writes WR_ADDR 100..111; three AG_START pulses; one DONE.
REQ-028 K=0 or L=5 with W=4 -> ERR and DONE same cycle, 2 cycles after START; no AG_START, RD_EN, WR_EN.
REQ-029 Window data {-5,-3,-9,-7}: without POOL_SCHED_RELU_EN WR_DATA=-3; with it WR_DATA=0.
REQ-030 EN low 5 cycles mid-RUN -> outputs frozen, write sequence identical to REQ-026; RESET asserted mid-RUN -> next cycle IDLE, BUSY=0, no DONE.
